// File: rtl/gol_pkg.sv
// Shared Game-of-Life constants and the board serializer state encoding.
// Imported by the update engine, the serializer and the display driver.
package gol_pkg;

  localparam int unsigned BOARD_ROWS = 16;
  localparam int unsigned BOARD_COLS = 16;
  localparam int unsigned BOARD_BITS = BOARD_ROWS * BOARD_COLS;
  localparam int unsigned ROW_IDX_W  = 4;

  // Serializer state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/gol_board_serializer_if.sv
// Board-in / row-out handshake bundle for gol_board_serializer.
//   board_in/board_valid/board_ready : snapshot capture handshake
//   row_data/row_idx/row_last/row_valid/row_ready : row stream handshake
// master = serializer side, slave = producer/consumer environment side.
interface gol_board_serializer_if
  import gol_pkg::*;
#(
  parameter int unsigned ROWS = BOARD_ROWS,
  parameter int unsigned COLS = BOARD_COLS
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS*COLS-1:0] board_in;
  logic                 board_valid;
  logic                 board_ready;
  logic [COLS-1:0]      row_data;
  logic [IDX_W-1:0]     row_idx;
  logic                 row_last;
  logic                 row_valid;
  logic                 row_ready;

  modport master (
    input  board_in, board_valid, row_ready,
    output board_ready, row_data, row_idx, row_last, row_valid
  );

  modport slave (
    output board_in, board_valid, row_ready,
    input  board_ready, row_data, row_idx, row_last, row_valid
  );

endinterface

// File: rtl/gol_board_serializer.sv
// Captures one Game-of-Life board snapshot and streams it out one row per beat,
// with an optional idle gap after every row beat except the last.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus (master) : snapshot capture handshake and row stream handshake
//   busy         : high while a frame is being streamed (SEND or GAP)
//   frame_count  : completed frames, wrapping
module gol_board_serializer
  import gol_pkg::*;
#(
  parameter int unsigned ROWS       = BOARD_ROWS,
  parameter int unsigned COLS       = BOARD_COLS,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned FCNT_W     = 16
)(
  input  logic                  clk,
  input  logic                  reset,
  gol_board_serializer_if.master bus,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_count
);

  localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned GAP_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  ser_state_e           state;
  logic [ROWS*COLS-1:0] shadow;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 board_ready_q;
  logic                 row_valid_q;
  logic                 row_last_q;
  logic [IDX_W-1:0]     row_idx_q;
  logic [COLS-1:0]      row_data_q;

  logic                 beat;
  logic [IDX_W-1:0]     idx_inc;
  logic [COLS-1:0]      next_row;

  // Row mux looks one row ahead so row_data can stay registered
  assign beat     = row_valid_q & bus.row_ready;
  assign idx_inc  = row_idx_q + IDX_W'(1);
  assign next_row = COLS'(shadow >> (32'(idx_inc) * COLS));

  assign bus.board_ready = board_ready_q;
  assign bus.row_valid   = row_valid_q;
  assign bus.row_last    = row_last_q;
  assign bus.row_idx     = row_idx_q;
  assign bus.row_data    = row_data_q;

  // Serializer FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shadow        <= '0;
      gap_cnt       <= '0;
      board_ready_q <= 1'b0;
      row_valid_q   <= 1'b0;
      row_last_q    <= 1'b0;
      row_idx_q     <= '0;
      row_data_q    <= '0;
      busy          <= 1'b0;
      frame_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.board_valid && board_ready_q) begin
            // board_in is sampled only here; later changes cannot reach this frame
            shadow        <= bus.board_in;
            row_idx_q     <= '0;
            row_data_q    <= bus.board_in[COLS-1:0];
            row_last_q    <= 1'b0;
            row_valid_q   <= 1'b1;
            board_ready_q <= 1'b0;
            busy          <= 1'b1;
            state         <= SEND;
          end else begin
            board_ready_q <= 1'b1;
            row_valid_q   <= 1'b0;
            busy          <= 1'b0;
          end
        end

        SEND: begin
          if (beat) begin
            if (row_idx_q == LAST_IDX) begin
              frame_count   <= frame_count + FCNT_W'(1);
              row_idx_q     <= '0;
              row_data_q    <= shadow[COLS-1:0];
              row_last_q    <= 1'b0;
              row_valid_q   <= 1'b0;
              board_ready_q <= 1'b1;
              busy          <= 1'b0;
              state         <= IDLE;
            end else if (GAP_CYCLES == 0) begin
              row_idx_q  <= idx_inc;
              row_data_q <= next_row;
              row_last_q <= (idx_inc == LAST_IDX);
            end else begin
              gap_cnt     <= GAP_W'(GAP_CYCLES - 1);
              row_valid_q <= 1'b0;
              state       <= GAP;
            end
          end
        end

        GAP: begin
          // Blanking: row_idx holds the just-sent row until the gap expires
          if (gap_cnt == '0) begin
            row_idx_q   <= idx_inc;
            row_data_q  <= next_row;
            row_last_q  <= (idx_inc == LAST_IDX);
            row_valid_q <= 1'b1;
            state       <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state         <= IDLE;
          row_valid_q   <= 1'b0;
          board_ready_q <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gol_board_serializer.sv
// Directed self-checking bench for gol_board_serializer.
// Three instances: default (no gap), GAP_CYCLES=3, and FCNT_W=4 for counter wrap.
module tb_gol_board_serializer;

  localparam int unsigned R = 16;
  localparam int unsigned C = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gol_board_serializer_if #(.ROWS(R), .COLS(C)) if0 ();
  gol_board_serializer_if #(.ROWS(R), .COLS(C)) if1 ();
  gol_board_serializer_if #(.ROWS(R), .COLS(C)) if2 ();

  logic        busy0, busy1, busy2;
  logic [15:0] fc0, fc1;
  logic [3:0]  fc2;

  gol_board_serializer #(.ROWS(R), .COLS(C), .GAP_CYCLES(0), .FCNT_W(16)) u_main (
    .clk(clk), .reset(reset), .bus(if0), .busy(busy0), .frame_count(fc0)
  );
  gol_board_serializer #(.ROWS(R), .COLS(C), .GAP_CYCLES(3), .FCNT_W(16)) u_gap (
    .clk(clk), .reset(reset), .bus(if1), .busy(busy1), .frame_count(fc1)
  );
  gol_board_serializer #(.ROWS(R), .COLS(C), .GAP_CYCLES(0), .FCNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .bus(if2), .busy(busy2), .frame_count(fc2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int n       = 0;

  logic [R*C-1:0] glider;
  logic [R*C-1:0] ones;
  logic [C-1:0]   exp_rows [R];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    glider = '0;
    glider[1]  = 1'b1;
    glider[18] = 1'b1;
    glider[32] = 1'b1;
    glider[33] = 1'b1;
    glider[34] = 1'b1;
    ones = '1;
    for (int r = 0; r < R; r++) exp_rows[r] = '0;
    exp_rows[0] = 16'h0002;
    exp_rows[1] = 16'h0004;
    exp_rows[2] = 16'h0007;

    if0.board_in = '0; if0.board_valid = 1'b0; if0.row_ready = 1'b1;
    if1.board_in = '0; if1.board_valid = 1'b0; if1.row_ready = 1'b1;
    if2.board_in = '0; if2.board_valid = 1'b0; if2.row_ready = 1'b1;

    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_board_ready", 64'(if0.board_ready), 64'd0);
    check("rst_row_valid",   64'(if0.row_valid),   64'd0);
    check("rst_row_idx",     64'(if0.row_idx),     64'd0);
    check("rst_row_data",    64'(if0.row_data),    64'd0);
    check("rst_row_last",    64'(if0.row_last),    64'd0);
    check("rst_busy",        64'(busy0),           64'd0);
    check("rst_frame_count", 64'(fc0),             64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("rel_board_ready", 64'(if0.board_ready), 64'd1);
    check("rel_gap_ready",   64'(if1.board_ready), 64'd1);

    // Glider frame, no gap, row_ready tied high
    if0.board_in = glider; if0.board_valid = 1'b1;
    step();
    acc_cyc = cyc;
    if0.board_valid = 1'b0;
    for (int r = 0; r < R; r++) begin
      check($sformatf("p1_valid_r%0d", r), 64'(if0.row_valid),   64'd1);
      check($sformatf("p1_idx_r%0d", r),   64'(if0.row_idx),     64'(r));
      check($sformatf("p1_data_r%0d", r),  64'(if0.row_data),    64'(exp_rows[r]));
      check($sformatf("p1_last_r%0d", r),  64'(if0.row_last),    64'(r == R - 1));
      check($sformatf("p1_bready_r%0d", r), 64'(if0.board_ready), 64'd0);
      check($sformatf("p1_busy_r%0d", r),  64'(busy0),           64'd1);
      step();
    end
    check("p1_ready_back", 64'(if0.board_ready), 64'd1);
    check("p1_valid_off",  64'(if0.row_valid),   64'd0);
    check("p1_busy_off",   64'(busy0),           64'd0);
    check("p1_period",     64'(cyc - acc_cyc + 1), 64'd17);
    check("p1_fcount",     64'(fc0),             64'd1);

    // Backpressure: five stalled cycles on row 2
    if0.board_valid = 1'b1;
    step();
    acc_cyc = cyc;
    if0.board_valid = 1'b0;
    step();
    step();
    check("p2_idx_at_stall", 64'(if0.row_idx), 64'd2);
    if0.row_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p2_valid_k%0d", k), 64'(if0.row_valid), 64'd1);
      check($sformatf("p2_data_k%0d", k),  64'(if0.row_data),  64'h0007);
      check($sformatf("p2_idx_k%0d", k),   64'(if0.row_idx),   64'd2);
      check($sformatf("p2_last_k%0d", k),  64'(if0.row_last),  64'd0);
      step();
    end
    check("p2_hold_data", 64'(if0.row_data), 64'h0007);
    if0.row_ready = 1'b1;
    step();
    check("p2_idx_after", 64'(if0.row_idx), 64'd3);
    n = 0;
    while (if0.board_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("p2_ready_back", 64'(if0.board_ready), 64'd1);
    check("p2_period",     64'(cyc - acc_cyc + 1), 64'd22);
    check("p2_fcount",     64'(fc0), 64'd2);

    // Capture isolation: new board offered mid-frame
    if0.board_in = glider; if0.board_valid = 1'b1;
    step();
    if0.board_valid = 1'b0;
    for (int r = 0; r < R; r++) begin
      check($sformatf("p3_data_r%0d", r),   64'(if0.row_data),    64'(exp_rows[r]));
      check($sformatf("p3_bready_r%0d", r), 64'(if0.board_ready), 64'd0);
      if (r == 4) begin
        if0.board_in = ones;
        if0.board_valid = 1'b1;
      end
      step();
    end
    check("p3_ready_back", 64'(if0.board_ready), 64'd1);
    check("p3_fcount1",    64'(fc0), 64'd3);
    step();
    if0.board_valid = 1'b0;
    for (int r = 0; r < R; r++) begin
      check($sformatf("p3b_valid_r%0d", r), 64'(if0.row_valid), 64'd1);
      check($sformatf("p3b_idx_r%0d", r),   64'(if0.row_idx),   64'(r));
      check($sformatf("p3b_data_r%0d", r),  64'(if0.row_data),  64'hFFFF);
      step();
    end
    check("p3_fcount2", 64'(fc0), 64'd4);

    // Reset mid-frame at row 7
    if0.board_in = glider; if0.board_valid = 1'b1;
    step();
    if0.board_valid = 1'b0;
    repeat (7) step();
    check("p4_idx_pre", 64'(if0.row_idx), 64'd7);
    reset = 1'b1;
    #1;
    check("p4_valid",  64'(if0.row_valid),   64'd0);
    check("p4_idx",    64'(if0.row_idx),     64'd0);
    check("p4_fcount", 64'(fc0),             64'd0);
    check("p4_bready", 64'(if0.board_ready), 64'd0);
    check("p4_busy",   64'(busy0),           64'd0);
    check("p4_data",   64'(if0.row_data),    64'd0);
    step();
    check("p4_bready_held", 64'(if0.board_ready), 64'd0);
    reset = 1'b0;
    step();
    check("p4_bready_rel", 64'(if0.board_ready), 64'd1);
    if0.board_valid = 1'b1;
    step();
    if0.board_valid = 1'b0;
    for (int r = 0; r < R; r++) begin
      check($sformatf("p4_idx_r%0d", r),  64'(if0.row_idx),  64'(r));
      check($sformatf("p4_data_r%0d", r), 64'(if0.row_data), 64'(exp_rows[r]));
      step();
    end
    check("p4_fcount_new", 64'(fc0), 64'd1);

    // GAP_CYCLES = 3 instance
    if1.board_in = glider; if1.board_valid = 1'b1;
    step();
    acc_cyc = cyc;
    if1.board_valid = 1'b0;
    for (int r = 0; r < R; r++) begin
      check($sformatf("p5_valid_r%0d", r), 64'(if1.row_valid), 64'd1);
      check($sformatf("p5_idx_r%0d", r),   64'(if1.row_idx),   64'(r));
      check($sformatf("p5_data_r%0d", r),  64'(if1.row_data),  64'(exp_rows[r]));
      check($sformatf("p5_last_r%0d", r),  64'(if1.row_last),  64'(r == R - 1));
      step();
      if (r < R - 1) begin
        for (int g = 0; g < 3; g++) begin
          check($sformatf("p5_gap_r%0d_g%0d", r, g),  64'(if1.row_valid), 64'd0);
          check($sformatf("p5_gbusy_r%0d_g%0d", r, g), 64'(busy1),        64'd1);
          step();
        end
      end
    end
    check("p5_ready_back", 64'(if1.board_ready), 64'd1);
    check("p5_valid_off",  64'(if1.row_valid),   64'd0);
    check("p5_period",     64'(cyc - acc_cyc + 1), 64'd62);
    check("p5_fcount",     64'(fc1), 64'd1);

    // FCNT_W = 4: 17 back-to-back frames
    check("p6_fcount0", 64'(fc2), 64'd0);
    if2.board_in = glider; if2.board_valid = 1'b1;
    step();
    for (int f = 1; f <= 17; f++) begin
      repeat (16) step();
      if (f >= 15) check($sformatf("p6_fcount_f%0d", f), 64'(fc2), 64'(f % 16));
      if (f < 17) step();
    end
    if2.board_valid = 1'b0;
    check("p6_busy_end", 64'(busy2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_board_serializer.md
Name: gol_board_serializer

Overview:
- Consumer end of the 256-bit generation bus produced by the Game-of-Life update engine.
- Captures one full board snapshot through a valid/ready handshake, then streams it out one row per beat over a second valid/ready interface.
- The downstream consumer is the LED-matrix row driver or a UART frame packer.
- An optional blanking gap between rows supports display ghosting control.

Parameters:
- ROWS, 16, board rows; must be >= 2.
- COLS, 16, board columns; also the row beat width.
- GAP_CYCLES, 0, idle cycles inserted after each accepted row beat except the last; range 0..255.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- board_in  input  ROWS*COLS  board snapshot; cell (r,c) = bit r*COLS+c.
- board_valid  input  1  board_in is valid.
- board_ready  output  1  block can accept a snapshot.
- row_data  output  COLS  current row = shadow[row_idx*COLS +: COLS].
- row_idx  output  clog2(ROWS)  index of the current row.
- row_last  output  1  high when row_idx == ROWS-1 and row_valid.
- row_valid  output  1  row beat is valid.
- row_ready  input  1  downstream accepts the beat.
- busy  output  1  high in SEND or GAP.
- frame_count  output  FCNT_W  number of completed frames, wrapping.

Behaviour:
Reset values (asynchronous, immediate on assertion):
- state = IDLE; board_ready = 0; row_valid = 0; row_idx = 0; row_data = 0; row_last = 0; busy = 0; frame_count = 0; shadow = 0.
- Reset mid-frame aborts at once; there is no partial-frame completion.

Registered outputs and bus rule:
- board_ready is registered and equals 1 exactly when the registered state is IDLE.
- On the first clk edge after reset release, board_ready becomes 1.

State machine IDLE / SEND / GAP:
- IDLE:
  - row_valid = 0.
  - On board_valid & board_ready: shadow <= board_in; row_idx <= 0; go to SEND.
  - board_ready drops the next cycle.
- SEND:
  - row_valid = 1.
  - On row_valid & row_ready with row_idx == ROWS-1: frame_count <= frame_count+1 (wraps all-ones to 0); row_idx <= 0; go to IDLE.
  - On row_valid & row_ready with row_idx < ROWS-1 and GAP_CYCLES == 0: row_idx <= row_idx+1; stay in SEND.
  - On row_valid & row_ready with row_idx < ROWS-1 and GAP_CYCLES > 0: gap_cnt <= GAP_CYCLES-1; go to GAP.
- GAP:
  - row_valid = 0.
  - gap_cnt decrements each cycle.
  - When gap_cnt == 0: row_idx <= row_idx+1; go to SEND.

Stability and capture rules:
- While row_valid & !row_ready, row_data, row_idx and row_last hold stable. Backpressure may last indefinitely.
- board_in is sampled only on the accept edge. Later changes to board_in do not affect the frame in flight.
- board_valid while busy is ignored (board_ready = 0). The upstream holds its data until accepted.

Latency and throughput:
- Accept at edge T: row 0 is valid in the cycle after T.
- With row_ready tied to 1 and GAP_CYCLES = 0: rows occupy ROWS consecutive cycles; board_ready returns 1 in the cycle after the last beat.
- Frame period is therefore ROWS+1 cycles (17 by default).
- Frame period with gaps is ROWS + 1 + (ROWS-1)*GAP_CYCLES.

Other rules:
- row_idx never exceeds ROWS-1; there is no wrap through an invalid index.

Decomposition:
- Shared package gol_pkg holds:
  - constants BOARD_ROWS = 16, BOARD_COLS = 16, BOARD_BITS = 256, ROW_IDX_W = 4;
  - the serializer state encoding (IDLE = 0, SEND = 1, GAP = 2).
- The update engine and the display driver import the same constants.
- No sub-module: the row mux and gap counter stay inline, giving a single module of about 150–200 lines.

Test Plan:
- Glider load, GAP_CYCLES = 0, row_ready = 1:
  - board_in bits {1, 18, 32, 33, 34} set.
  - Required beats: row0 = 16'h0002, row1 = 16'h0004, row2 = 16'h0007, rows 3–15 = 0.
  - row_last only on row_idx = 15; frame_count = 1; board_ready high 17 cycles after accept.
- Backpressure:
  - row_ready low for 5 cycles while row_idx = 2.
  - row_valid stays 1 and row_data stays 16'h0007 throughout.
  - Beat completes on the first row_ready = 1; total frame is 22 cycles.
- GAP_CYCLES = 3:
  - row_valid shows 3-cycle low gaps between beats and none after row 15.
  - Frame period = 16 + 1 + 45 = 62 cycles.
- Capture isolation:
  - Toggle board_in to all-ones and hold board_valid = 1 mid-frame.
  - The current frame still streams glider values.
  - The second board is accepted only once board_ready = 1; its rows all read 16'hFFFF.
- Reset mid-frame:
  - Assert reset at row_idx = 7.
  - Immediately: row_valid = 0, row_idx = 0, frame_count = 0, board_ready = 0.
  - After release: board_ready = 1 one edge later; a new frame streams from row 0.
- Counter wrap:
  - With FCNT_W = 4, run 17 back-to-back frames.
  - frame_count reads 15, then 0, then 1.
